csr_ctrl: RTL

CSR_CTRL -- requirements
Module: csr_ctrl

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_alu.sv | 33 +++
 rtl/csr_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR controller.
// The MSTAT state is only present when CSR_MSTATUS_STACK_EN is defined.
package csr_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

`ifdef CSR_MSTATUS_STACK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MSTAT, ST_RESP} csr_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} csr_state_e;
`endif

  function automatic logic csr_addr_legal(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write value and write enable for CSRRW/CSRRS/CSRRC.
module csr_alu
  import csr_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src,
  input  logic              src_zero,
  input  logic [DATA_W-1:0] old,
  output logic [DATA_W-1:0] wdata,
  output logic              wen
);

  always_comb begin
    wdata = '0;
    wen   = 1'b0;
    case (op)
      OP_CSRRW: begin
        wdata = src;
        wen   = 1'b1;
      end
      OP_CSRRS: begin
        wdata = old | src;
        wen   = !src_zero;
      end
      OP_CSRRC: begin
        wdata = old & ~src;
        wen   = !src_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: CSR read-modify-write, ECALL and MRET.
// Define CSR_MSTATUS_STACK_EN to add the MSTAT state that stacks/unstacks mstatus.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_zero,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_target,
  output logic        resp_illegal,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr1,
  output logic [31:0] csr_wdata1,
  output logic        csr_wen1,
  output logic [11:0] csr_waddr2,
  output logic [31:0] csr_wdata2,
  output logic        csr_wen2
);

  csr_state_e state, state_nxt;

  logic [2:0]        op_q;
  logic [11:0]       addr_q;
  logic [DATA_W-1:0] src_q;
  logic              src_zero_q;
  logic [DATA_W-1:0] pc_q;

  logic [DATA_W-1:0] alu_wdata;
  logic              alu_wen;
  logic              legal;

  logic [DATA_W-1:0] rdata_nxt;
  logic [DATA_W-1:0] target_nxt;
  logic              redirect_nxt;
  logic              illegal_nxt;

`ifdef CSR_MSTATUS_STACK_EN
  function automatic logic [DATA_W-1:0] mstatus_stack(input logic [DATA_W-1:0] v,
                                                      input logic trap_entry);
    logic [DATA_W-1:0] r;
    r = v;
    if (trap_entry) begin
      r[MSTATUS_MPIE] = v[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
    end else begin
      r[MSTATUS_MIE]  = v[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
    end
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction
`endif

  csr_alu u_alu (
    .op       (op_q),
    .src      (src_q),
    .src_zero (src_zero_q),
    .old      (csr_rdata),
    .wdata    (alu_wdata),
    .wen      (alu_wen)
  );

  // ECALL/MRET ignore the address field; CSR ops need one of the four implemented CSRs.
  always_comb begin
    case (op_q)
      OP_CSRRW, OP_CSRRS, OP_CSRRC: legal = csr_addr_legal(addr_q);
      OP_ECALL, OP_MRET:            legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    csr_raddr    = addr_q;
    csr_waddr1   = '0;
    csr_wdata1   = '0;
    csr_wen1     = 1'b0;
    csr_waddr2   = '0;
    csr_wdata2   = '0;
    csr_wen2     = 1'b0;
    rdata_nxt    = resp_rdata;
    target_nxt   = resp_target;
    redirect_nxt = resp_redirect;
    illegal_nxt  = resp_illegal;

    case (state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        rdata_nxt    = '0;
        target_nxt   = '0;
        redirect_nxt = 1'b0;
        illegal_nxt  = !legal;
        state_nxt    = ST_RESP;
        case (op_q)
          OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
            csr_raddr = addr_q;
            if (legal) begin
              rdata_nxt  = csr_rdata;
              csr_wen1   = alu_wen;
              csr_waddr1 = addr_q;
              csr_wdata1 = alu_wdata;
            end
          end
          OP_ECALL: begin
            csr_raddr    = CSR_MTVEC;
            csr_wen1     = 1'b1;
            csr_waddr1   = CSR_MEPC;
            csr_wdata1   = pc_q;
            csr_wen2     = 1'b1;
            csr_waddr2   = CSR_MCAUSE;
            csr_wdata2   = MCAUSE_ECALL;
            redirect_nxt = 1'b1;
            target_nxt   = csr_rdata;
`ifdef CSR_MSTATUS_STACK_EN
            state_nxt    = ST_MSTAT;
`endif
          end
          OP_MRET: begin
            csr_raddr    = CSR_MEPC;
            redirect_nxt = 1'b1;
            target_nxt   = csr_rdata;
`ifdef CSR_MSTATUS_STACK_EN
            state_nxt    = ST_MSTAT;
`endif
          end
          default: ;
        endcase
      end
`ifdef CSR_MSTATUS_STACK_EN
      ST_MSTAT: begin
        csr_raddr  = CSR_MSTATUS;
        csr_wen1   = 1'b1;
        csr_waddr1 = CSR_MSTATUS;
        csr_wdata1 = mstatus_stack(csr_rdata, op_q == OP_ECALL);
        state_nxt  = ST_RESP;
      end
`endif
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A request interrupted by reset must leave the CSR file untouched.
    if (rst) begin
      csr_wen1 = 1'b0;
      csr_wen2 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      resp_rdata    <= '0;
      resp_target   <= '0;
      resp_redirect <= 1'b0;
      resp_illegal  <= 1'b0;
    end else begin
      state         <= state_nxt;
      resp_rdata    <= rdata_nxt;
      resp_target   <= target_nxt;
      resp_redirect <= redirect_nxt;
      resp_illegal  <= illegal_nxt;
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_q       <= req_op;
      addr_q     <= req_csr_addr;
      src_q      <= req_src;
      src_zero_q <= req_src_zero;
      pc_q       <= req_pc;
    end
  end

endmodule
